// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp codes, phase states and default timer durations
// ALL_RED_CLEARANCE_EN adds the two all-red clearance states.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  localparam int GREEN_CYCLES     = 20;
  localparam int EXT_GREEN_CYCLES = 30;
  localparam int YELLOW_CYCLES    = 5;

  // The watchdog limit must outlast the longest phase the timer can produce
  localparam int LONGEST_TIMER_CYCLES =
    (EXT_GREEN_CYCLES > GREEN_CYCLES)
      ? ((EXT_GREEN_CYCLES > YELLOW_CYCLES) ? EXT_GREEN_CYCLES : YELLOW_CYCLES)
      : ((GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    FAULT     = 3'd4
`ifdef ALL_RED_CLEARANCE_EN
    ,
    ALL_RED_1 = 3'd5,
    ALL_RED_2 = 3'd6
`endif
  } phase_t;

  function automatic logic [1:0] ns_lamp(input phase_t p);
    case (p)
      NS_GREEN:  return LAMP_GREEN;
      NS_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

  function automatic logic [1:0] ew_lamp(input phase_t p);
    case (p)
      EW_GREEN:  return LAMP_GREEN;
      EW_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

  // Timer runs the short yellow duration for every clearance phase
  function automatic logic clear_mode(input phase_t p);
    case (p)
      NS_YELLOW, EW_YELLOW: return 1'b1;
`ifdef ALL_RED_CLEARANCE_EN
      ALL_RED_1, ALL_RED_2: return 1'b1;
`endif
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// rtl/phase_watchdog.sv - saturating no-expiry counter with timeout flag
// timeout marks the edge on which the count would reach LIMIT.
module phase_watchdog #(
  parameter int LIMIT = 64,
  parameter int W     = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = en && !clr && (count == W'(LIMIT - 1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - NS/EW adaptive phase FSM driving the phase timer and lamps
// ALL_RED_CLEARANCE_EN inserts all-red clearance after each yellow.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int WDOG_CYCLES = 64,
  parameter int WDOG_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       expired,
  output logic       start,
  output logic       extend,
  output logic       yellow_mode,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       fault
);

  if ((WDOG_CYCLES <= LONGEST_TIMER_CYCLES + 3) || (WDOG_CYCLES >= (1 << WDOG_W))) begin : g_bad_cfg
    $error("traffic_phase_ctrl: WDOG_CYCLES does not fit the timer phases or WDOG_W");
  end

  phase_t state;
  phase_t next_state;
  logic   restart;
  logic   accept;
  logic   wdog_timeout;

  assign accept = start && expired;

  always_comb begin
    next_state = state;
    case (state)
      NS_GREEN:  next_state = ew_car ? NS_YELLOW : NS_GREEN;
      EW_GREEN:  next_state = ns_car ? EW_YELLOW : EW_GREEN;
`ifdef ALL_RED_CLEARANCE_EN
      NS_YELLOW: next_state = ALL_RED_1;
      EW_YELLOW: next_state = ALL_RED_2;
      ALL_RED_1: next_state = EW_GREEN;
      ALL_RED_2: next_state = NS_GREEN;
`else
      NS_YELLOW: next_state = EW_GREEN;
      EW_YELLOW: next_state = NS_GREEN;
`endif
      default:   next_state = state;
    endcase
  end

  phase_watchdog #(
    .LIMIT (WDOG_CYCLES),
    .W     (WDOG_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (start),
    .timeout (wdog_timeout)
  );

  // FAULT takes no branch below, so it holds until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= NS_GREEN;
      restart     <= 1'b1;
      start       <= 1'b0;
      extend      <= 1'b0;
      yellow_mode <= 1'b0;
      ns_light    <= LAMP_GREEN;
      ew_light    <= LAMP_RED;
      fault       <= 1'b0;
    end else if (state != FAULT) begin
      if (wdog_timeout) begin
        state       <= FAULT;
        restart     <= 1'b0;
        start       <= 1'b0;
        extend      <= 1'b0;
        yellow_mode <= 1'b0;
        ns_light    <= LAMP_RED;
        ew_light    <= LAMP_RED;
        fault       <= 1'b1;
      end else if (restart) begin
        restart <= 1'b0;
        start   <= 1'b1;
        if (state == NS_GREEN) begin
          extend <= ns_car & ~ew_car;
        end else if (state == EW_GREEN) begin
          extend <= ew_car & ~ns_car;
        end
      end else if (accept) begin
        state       <= next_state;
        restart     <= 1'b1;
        start       <= 1'b0;
        extend      <= 1'b0;
        yellow_mode <= clear_mode(next_state);
        ns_light    <= ns_lamp(next_state);
        ew_light    <= ew_lamp(next_state);
      end
    end
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Phase state machine for a two-way (NS/EW) adaptive intersection, directly upstream of the green/yellow phase timer.
- Drives the timer's start, extend and yellow_mode inputs, and consumes its one-cycle expired pulse.
- Decides the green extension and rest-in-green from vehicle sensors, and drives the lamp codes for both approaches.
- Adds a watchdog that forces a latched all-red fault if the timer stops producing expiries.

Parameters:
- WDOG_CYCLES, 64, cycles without an expired pulse (while timing) before entering FAULT; must exceed the longest timer phase plus 3.
- WDOG_W, 7, watchdog counter width; must hold WDOG_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ns_car  in  1  vehicle present on NS approach (synchronous to clk)
- ew_car  in  1  vehicle present on EW approach
- expired  in  1  timer expiry pulse, one cycle wide
- start  out  1  timer run enable
- extend  out  1  timer extended-green select
- yellow_mode  out  1  timer yellow-duration select
- ns_light  out  2  NS lamp: 0=RED, 1=YELLOW, 2=GREEN
- ew_light  out  2  EW lamp, same encoding
- fault  out  1  watchdog fault, latched

Behaviour:
- All outputs registered. Reset (rst low, asynchronous): state=NS_GREEN, restart flag set, start=0, extend=0, yellow_mode=0, ns_light=GREEN, ew_light=RED, fault=0, watchdog=0.
- States: NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, FAULT (plus the ALL_RED states under the optional feature).
- Restart cycle: every phase entry, including re-entry of the same green, spends exactly one cycle with start=0, which clears the timer counter.
  - start=1 from the following cycle until the next phase entry.
  - expired is ignored in any cycle where start is 0.
- Timing: with timer defaults 20/30/5, measured from entry edge to exit edge, green = 23 cycles, extended green = 33 cycles, yellow = 8 cycles.
- Extend latch: sampled in the restart cycle of each green.
  - NS_GREEN: extend = ns_car & ~ew_car.
  - EW_GREEN: extend = ew_car & ~ns_car.
  - Held constant for the whole phase; extend=0 in all non-green states.
- yellow_mode: 1 in yellow and all-red states, 0 otherwise; it changes only on phase entry.
- Transitions, taken on the clock edge where expired=1 and start=1:
  - NS_GREEN: to NS_YELLOW if ew_car=1. Otherwise re-enter NS_GREEN (rest in green), with a new restart cycle and extend re-latched.
  - NS_YELLOW to EW_GREEN.
  - EW_GREEN mirrors NS_GREEN using ns_car.
  - EW_YELLOW to NS_GREEN.
- Lamps follow the state on the same edge:
  - NS_GREEN: ns GREEN, ew RED. NS_YELLOW: ns YELLOW, ew RED.
  - EW states mirror these.
  - FAULT and ALL_RED: both RED.
- Watchdog:
  - Clears on every phase entry and on every accepted expired pulse.
  - Otherwise increments while start=1 and saturates.
  - When it reaches WDOG_CYCLES: enter FAULT, with start=0, both RED, fault=1.
- FAULT exits only via reset.
- Sensor changes mid-phase have no effect except at the expiry decision.
- If expired and a sensor change arrive on the same edge, the decision uses the sensor value sampled at that edge.
- Reset mid-phase returns to the reset state immediately.

Optional Feature:
- Macro: ALL_RED_CLEARANCE_EN.
- Defined:
  - Adds ALL_RED_1 between NS_YELLOW and EW_GREEN, and ALL_RED_2 between EW_YELLOW and NS_GREEN.
  - Both use yellow_mode=1 with a restart cycle, so each lasts 8 cycles, both lamps RED.
  - Each exits on an accepted expired pulse.
- Undefined: yellow goes directly to the opposing green; the ALL_RED states and their encodings are absent.

Decomposition:
- Shared package traffic_pkg holds:
  - lamp code constants LAMP_RED=2'd0, LAMP_YELLOW=2'd1, LAMP_GREEN=2'd2;
  - the phase state enum typedef;
  - the default timer durations 20/30/5, also used by the bench.
- One sub-module, phase_watchdog: saturating counter with clear and enable, and a timeout flag output.
- The FSM stays in traffic_phase_ctrl.

Test Plan:
- Reset, then hold ew_car=1, ns_car=0 with the real timer: NS green 23 cycles, NS yellow 8, EW green 23; extend stays 0 in NS_GREEN.
- ns_car=1, ew_car=0 at the NS restart cycle, then ew_car=1 after 10 cycles: extend=1, NS green lasts 33 cycles, then yellow.
- Both sensors 0: NS_GREEN re-entered repeatedly, with a start=0 pulse every 23 cycles; ew_light stays RED.
- Tie expired low: fault=1 and both RED exactly WDOG_CYCLES=64 cycles after start rises. Expired pulses afterwards cause no exit; rst low recovers.
- Assert rst mid-EW_YELLOW: outputs immediately show ns GREEN, ew RED, start=0, and the restart sequence reruns.
- With ALL_RED_CLEARANCE_EN defined: NS_YELLOW, then both RED for 8 cycles with yellow_mode=1, then EW_GREEN.
